// File: rtl/btn_toggle_pulse.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM with a saturating
// qualification counter, and registered press (toggle) / release pulses.
module btn_toggle_pulse #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic n_rst,
   input  logic btn_in,
   output logic btn_level,
   output logic t_pulse,
   output logic rel_pulse
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HIGH = 2'd1,
      PRESSED   = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_r;
   logic             s2_r;
   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= btn_in;
         s2_r <= s1_r;
      end
   end

   // Debounce FSM; pulses default low every cycle so they last exactly one cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         btn_level <= 1'b0;
         t_pulse   <= 1'b0;
         rel_pulse <= 1'b0;
      end else begin
         t_pulse   <= 1'b0;
         rel_pulse <= 1'b0;
         case (state_r)
            IDLE: begin
               btn_level <= 1'b0;
               if (s2_r) begin
                  state_r <= WAIT_HIGH;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            WAIT_HIGH: begin
               if (!s2_r) begin
                  state_r <= IDLE;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r   <= PRESSED;
                  cnt_r     <= CNT_ZERO;
                  btn_level <= 1'b1;
                  t_pulse   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            PRESSED: begin
               btn_level <= 1'b1;
               if (!s2_r) begin
                  state_r <= WAIT_LOW;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            WAIT_LOW: begin
               if (s2_r) begin
                  state_r <= PRESSED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r   <= IDLE;
                  cnt_r     <= CNT_ZERO;
                  btn_level <= 1'b0;
                  rel_pulse <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= CNT_ZERO;
               btn_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Scoreboard bench: a run-length reference model predicts every cycle's outputs
// (plus a downstream T flip-flop) and a negedge monitor compares them.
module tb_btn_toggle_pulse;

   localparam int D = 4;

   logic clk = 1'b0;
   logic n_rst;
   logic btn_in;
   logic btn_level, t_pulse, rel_pulse;
   logic q;

   int checks = 0;
   int passed = 0;

   logic [3:0] exp_q[$];

   // Reference model state: two-edge input delay, accepted level, length of the
   // current run of samples that disagree with it, and the expected T-FF output.
   logic d1, d2, lvl, t_prev, q_m;
   int   run;

   btn_toggle_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk(clk), .n_rst(n_rst), .btn_in(btn_in),
      .btn_level(btn_level), .t_pulse(t_pulse), .rel_pulse(rel_pulse)
   );

   always #5 clk = ~clk;

   // Downstream T flip-flop fed by the toggle pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) q <= 1'b0;
      else        q <= q ^ t_pulse;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got level/t/rel/q=%b required %b at %0t", name, act, req, $time);
   endtask

   task automatic model_clear();
      d1 = 1'b0; d2 = 1'b0; lvl = 1'b0; run = 0; t_prev = 1'b0; q_m = 1'b0;
   endtask

   // Called at each rising edge: predict the outputs that edge produces.
   task automatic model_edge();
      logic sample, t, r;
      if (!n_rst) begin
         model_clear();
         exp_q.push_back(4'b0000);
      end else begin
         sample = d2;
         d2 = d1;
         d1 = btn_in;
         q_m = q_m ^ t_prev;
         t = 1'b0;
         r = 1'b0;
         if (sample != lvl) begin
            run++;
            if (run == D) begin
               lvl = sample;
               run = 0;
               t = sample;
               r = ~sample;
            end
         end else begin
            run = 0;
         end
         t_prev = t;
         exp_q.push_back({lvl, t, r, q_m});
      end
   endtask

   task automatic drive(input logic b);
      @(posedge clk);
      model_edge();
      #1 btn_in = b;
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) drive(b);
   endtask

   // Assert reset mid-cycle, verify outputs clear without a clock, hold, release.
   task automatic mid_reset(input int n);
      @(posedge clk);
      model_edge();
      #2 n_rst = 1'b0;
      exp_q.delete();
      model_clear();
      exp_q.push_back(4'b0000);
      #1 check("async_reset", {btn_level, t_pulse, rel_pulse, q}, 4'b0000);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
      end
      #1 n_rst = 1'b1;
   endtask

   // Monitor: one expected output set per clock, compared away from the edge.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", {btn_level, t_pulse, rel_pulse, q}, e);
         end
      end
   end

   initial begin
      int guard;
      logic b;
      n_rst  = 1'b0;
      btn_in = 1'b0;
      model_clear();
      #1 check("reset_state", {btn_level, t_pulse, rel_pulse, q}, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         model_edge();
      end
      #1 n_rst = 1'b1;

      hold(1'b0, 4);
      // clean press, held: single toggle, no auto-repeat
      hold(1'b1, 15);
      // release
      hold(1'b0, 12);
      // bounce 1,1,0,1,1,1,1,1 then held
      drive(1'b1); drive(1'b1); drive(1'b0);
      hold(1'b1, 12);
      hold(1'b0, 12);
      // short glitch of 3 cycles
      hold(1'b1, 3);
      hold(1'b0, 10);
      // press for 20 cycles, then release
      hold(1'b1, 20);
      hold(1'b0, 12);
      // reset during press qualification, button held through release
      hold(1'b1, 4);
      mid_reset(2);
      hold(1'b1, 12);
      hold(1'b0, 12);
      // reset while pressed
      hold(1'b1, 10);
      mid_reset(1);
      hold(1'b0, 10);

      // randomized runs: mix of glitches, bounces and accepted levels
      b = 1'b0;
      for (int k = 0; k < 400; k++) begin
         b = ~b;
         hold(b, $urandom_range(1, 9));
         if ($urandom_range(0, 39) == 0) mid_reset($urandom_range(0, 3));
      end
      hold(1'b0, 10);

      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/btn_toggle_pulse.md
# btn_toggle_pulse

Debounces a raw mechanical push-button input and converts each clean press into a single-cycle toggle pulse. It is the stage directly upstream of the T flip-flop: `t_pulse` drives the flip-flop's `t` input so that one physical press toggles `q` exactly once. It also exports the debounced level and a release pulse for LEDs and other consumers. The block is fully synchronous to `clk` except for the asynchronous active-low reset.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive synchronized samples of a new level required before that level is accepted. Legal range is 2 to 2^CNT_W − 1.
- `CNT_W`, default 16: width of the debounce counter.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `n_rst`  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `btn_in`  input  1  raw button, active-high, asynchronous to `clk`, may bounce.
- `btn_level`  output  1  debounced button level (registered).
- `t_pulse`  output  1  one-cycle high pulse on each accepted press (registered); connects to the T-FF `t` input.
- `rel_pulse`  output  1  one-cycle high pulse on each accepted release (registered).

## Operation
- **Synchronizer:** two flops, `btn_in` → `s1` → `s2`. Only `s2` (the "sample") feeds the FSM. Nothing else touches `btn_in`.
- **FSM states:**
  - IDLE: stable low.
  - WAIT_HIGH: qualifying a press.
  - PRESSED: stable high.
  - WAIT_LOW: qualifying a release.
- **IDLE:**
  - sample = 1 → WAIT_HIGH, cnt ← 1.
  - sample = 0 → stay, cnt ← 0.
- **WAIT_HIGH:**
  - sample = 0 → IDLE, cnt ← 0. No output change.
  - sample = 1 and cnt = DEBOUNCE_CYCLES−1 → PRESSED, cnt ← 0, `btn_level` ← 1, `t_pulse` ← 1.
  - sample = 1 otherwise → cnt ← cnt+1.
- **PRESSED:** mirror of IDLE.
  - sample = 0 → WAIT_LOW, cnt ← 1.
  - sample = 1 → stay.
- **WAIT_LOW:** mirror of WAIT_HIGH.
  - sample = 1 → PRESSED, cnt ← 0.
  - sample = 0 and cnt = DEBOUNCE_CYCLES−1 → IDLE, `btn_level` ← 0, `rel_pulse` ← 1.
  - sample = 0 otherwise → cnt ← cnt+1.
- **Pulses:** `t_pulse` and `rel_pulse` are high for exactly one cycle and default to 0 on every other cycle. They are never high in the same cycle.
- **Counter:** `cnt` never exceeds DEBOUNCE_CYCLES−1 and never wraps. There are no unreachable-state hazards: any illegal state encoding returns to IDLE with all outputs 0.

## Timing
- **Reset values:** `s1`, `s2`, `cnt`, `btn_level`, `t_pulse` and `rel_pulse` are all 0; state is IDLE. Reset applies asynchronously on `n_rst` falling. Release is synchronous to `clk` from the next edge.
- **Press latency:** `btn_in` is stable high from before clock edge 0. `s2` = 1 after edge 1. Samples are taken at edges 2 … DEBOUNCE_CYCLES+1. `btn_level` and `t_pulse` go high after edge DEBOUNCE_CYCLES+1, so the latency is DEBOUNCE_CYCLES+1 edges.
- **Release latency:** identical, DEBOUNCE_CYCLES+1 edges, ending in `rel_pulse`.
- **Pulse width:** `t_pulse` is high for exactly the cycle following the accepting edge. The T-FF samples it on the next edge, so `q` toggles one edge after `t_pulse` rises.
- **Bounce handling:** any sample of the old level during WAIT_* restarts qualification from zero. A glitch shorter than DEBOUNCE_CYCLES samples produces no output activity.
- **Holding the button:** the button held indefinitely produces exactly one `t_pulse`. There is no auto-repeat.
- **Reset mid-qualification:** the cycle count is discarded and no pulse is emitted.
- **Button held through reset release:** treated as a new press. `t_pulse` fires DEBOUNCE_CYCLES+1 edges after the first edge following reset release.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. Reset: assert `n_rst` = 0 mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
2. Clean press: `btn_in` 0→1 before edge 0 and held → `btn_level` and `t_pulse` rise after edge 5. `t_pulse` falls after edge 6. `btn_level` stays 1.
3. Bounce: `btn_in` sequence 1,1,0,1,1,1,1,1 (one value per cycle) → exactly one `t_pulse`, 5 edges after the last 0→1 transition. No pulse earlier.
4. Short glitch: `btn_in` high for 3 cycles, then low → `btn_level`, `t_pulse` and `rel_pulse` remain 0 throughout.
5. Press then release: hold high for 20 cycles, then low → one `t_pulse`, then one `rel_pulse` 5 edges after the falling input. With a downstream T-FF attached, `q` goes 0→1 and stays 1 after the release.
6. Reset during WAIT_HIGH: pulse `n_rst` low after 2 qualifying samples while `btn_in` stays high → no pulse before reset. After release, `t_pulse` fires 5 edges later.
